// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_pkg                                                      |
// | Description : Shared opcode map, flag bit positions, FSM state encoding    |
// |               and small decode helpers for multicycle_alu.                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package alu_pkg;

  // Operation codes (5-bit opsel). Codes 21..31 are undefined.
  localparam logic [4:0] OP_SHORT_B = 5'd0;   // pass srcB
  localparam logic [4:0] OP_ADD     = 5'd1;
  localparam logic [4:0] OP_SUB     = 5'd2;
  localparam logic [4:0] OP_INC     = 5'd3;
  localparam logic [4:0] OP_DEC     = 5'd4;
  localparam logic [4:0] OP_AND     = 5'd5;
  localparam logic [4:0] OP_OR      = 5'd6;
  localparam logic [4:0] OP_XOR     = 5'd7;
  localparam logic [4:0] OP_NOT     = 5'd8;
  localparam logic [4:0] OP_NEG     = 5'd9;
  localparam logic [4:0] OP_RSL     = 5'd10;
  localparam logic [4:0] OP_LSL     = 5'd11;
  localparam logic [4:0] OP_RSA     = 5'd12;
  localparam logic [4:0] OP_LSA     = 5'd13;
  localparam logic [4:0] OP_RSR     = 5'd14;
  localparam logic [4:0] OP_LSR     = 5'd15;
  localparam logic [4:0] OP_RSC     = 5'd16;
  localparam logic [4:0] OP_LSC     = 5'd17;
  localparam logic [4:0] OP_MUL     = 5'd18;
  localparam logic [4:0] OP_DIV     = 5'd19;
  localparam logic [4:0] OP_MOD     = 5'd20;

  // Bit positions inside the 4-bit flags word {ZF,NF,CF,OF}
  localparam int FLAG_Z = 3;
  localparam int FLAG_N = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_MULDIV = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  function automatic logic is_shift_op(input logic [4:0] op);
    return (op >= OP_RSL) && (op <= OP_LSC);
  endfunction

  function automatic logic [3:0] pack_flags(input logic z, input logic n,
                                            input logic c, input logic o);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_Z] = z;
    f[FLAG_N] = n;
    f[FLAG_C] = c;
    f[FLAG_O] = o;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_muldiv.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : seq_muldiv                                                   |
// | Description : Iterative unsigned multiply (shift-add) / restoring divide.  |
// |               One step per clock, WIDTH steps total; the first step is     |
// |               performed on the start edge so done rises WIDTH cycles after |
// |               start. Results are held until the next start.                |
// | Ports       : clk, rst (sync, active high), start, is_div, a, b            |
// |               busy, done (1-cycle pulse), hi, lo                           |
// |               MUL: {hi,lo} = a*b     DIV: lo = a/b, hi = a%b               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module seq_muldiv #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W       = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] C_FIRST_CNT = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] r_hi, r_lo, r_b;
  logic             r_div, r_busy, r_done;
  logic [CNT_W-1:0] r_cnt;

  logic [WIDTH-1:0] w_hi, w_lo, w_b, w_hi_nxt, w_lo_nxt;
  logic             w_div;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shl;

  // Step source is the fresh operand set on start, otherwise the running state.
  always_comb begin
    w_hi  = start ? '0     : r_hi;
    w_lo  = start ? a      : r_lo;
    w_b   = start ? b      : r_b;
    w_div = start ? is_div : r_div;

    // multiply: conditionally add multiplicand, then shift {acc,q} right
    w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, w_b} : '0);
    // divide: shift next dividend bit into the partial remainder
    w_shl = {w_hi, w_lo[WIDTH-1]};

    w_hi_nxt = w_sum[WIDTH:1];
    w_lo_nxt = {w_sum[0], w_lo[WIDTH-1:1]};
    if (w_div) begin
      if (w_shl >= {1'b0, w_b}) begin
        w_hi_nxt = WIDTH'(w_shl - {1'b0, w_b});
        w_lo_nxt = {w_lo[WIDTH-2:0], 1'b1};
      end else begin
        w_hi_nxt = w_shl[WIDTH-1:0];
        w_lo_nxt = {w_lo[WIDTH-2:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_b    <= '0;
      r_div  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_hi   <= w_hi_nxt;
        r_lo   <= w_lo_nxt;
        r_b    <= b;
        r_div  <= is_div;
        r_cnt  <= C_FIRST_CNT;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_hi  <= w_hi_nxt;
        r_lo  <= w_lo_nxt;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1)) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: rtl/multicycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : multicycle_alu                                               |
// | Description : Multi-cycle ALU. Single-cycle arithmetic/logic ops, 1-bit-   |
// |               per-cycle shifts/rotates, iterative MUL/DIV/MOD.             |
// | Ports       : clk, rst (sync, active high)                                 |
// |               start, opsel[4:0], srcA, srcB, Cflag, Oflag   (inputs)       |
// |               ready, done (1-cycle pulse), res, extra_res,                 |
// |               flags[3:0] = {ZF,NF,CF,OF}                    (outputs)      |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module multicycle_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       opsel,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             Cflag,
  input  logic             Oflag,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] extra_res,
  output logic [3:0]       flags
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;
  localparam int MSB   = WIDTH - 1;

  state_t           r_state;
  logic             r_ready, r_done;
  logic [WIDTH-1:0] r_res, r_extra, r_sh;
  logic [3:0]       r_flags;
  logic [4:0]       r_op;
  logic             r_c, r_of;
  logic [CNT_W-1:0] r_cnt;

  // single-cycle decode
  logic [SH_W-1:0]  w_n;
  logic             w_to_shift, w_to_md, w_md_start;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_one_res, w_one_extra;
  logic             w_one_c, w_one_o, w_one_keep;
  logic [3:0]       w_one_flags;

  // shift step
  logic [WIDTH-1:0] w_sh_nxt;
  logic             w_c_nxt, w_of_nxt;

  // mul/div unit
  logic             w_md_busy, w_md_done;
  logic [WIDTH-1:0] w_md_hi, w_md_lo, w_md_res, w_md_extra;
  logic [3:0]       w_md_flags;

  assign w_n        = srcB[SH_W-1:0];   // srcB mod WIDTH
  assign w_to_shift = is_shift_op(opsel) && (w_n != '0);
  assign w_to_md    = (opsel == OP_MUL) ||
                      (((opsel == OP_DIV) || (opsel == OP_MOD)) && (srcB != '0));
  assign w_md_start = start && (r_state == S_IDLE) && w_to_md && !w_md_busy;

  always_comb begin
    w_sum       = '0;
    w_one_res   = '0;
    w_one_extra = '0;
    w_one_c     = Cflag;
    w_one_o     = Oflag;
    w_one_keep  = 1'b0;
    case (opsel)
      OP_SHORT_B: w_one_res = srcB;
      OP_ADD: begin
        w_sum     = {1'b0, srcA} + {1'b0, srcB};
        w_one_res = w_sum[MSB:0];
        w_one_c   = w_sum[WIDTH];
        w_one_o   = (srcA[MSB] == srcB[MSB]) && (w_sum[MSB] != srcA[MSB]);
      end
      OP_SUB: begin
        w_sum     = {1'b0, srcA} - {1'b0, srcB};
        w_one_res = w_sum[MSB:0];
        w_one_c   = w_sum[WIDTH];
        w_one_o   = (srcA[MSB] != srcB[MSB]) && (w_sum[MSB] != srcA[MSB]);
      end
      OP_INC: begin
        w_sum     = {1'b0, srcA} + (WIDTH+1)'(1);
        w_one_res = w_sum[MSB:0];
        w_one_c   = w_sum[WIDTH];
        w_one_o   = !srcA[MSB] && w_sum[MSB];
      end
      OP_DEC: begin
        w_sum     = {1'b0, srcA} - (WIDTH+1)'(1);
        w_one_res = w_sum[MSB:0];
        w_one_c   = w_sum[WIDTH];
        w_one_o   = srcA[MSB] && !w_sum[MSB];
      end
      OP_AND: w_one_res = srcA & srcB;
      OP_OR:  w_one_res = srcA | srcB;
      OP_XOR: w_one_res = srcA ^ srcB;
      OP_NOT: w_one_res = ~srcA;
      OP_NEG: w_one_res = '0 - srcA;
      // zero-length shift finishes immediately with srcA unchanged
      OP_RSL, OP_LSL, OP_RSA, OP_LSA,
      OP_RSR, OP_LSR, OP_RSC, OP_LSC: w_one_res = srcA;
      // only reached here on a zero divisor
      OP_DIV, OP_MOD: begin
        w_one_res   = '1;
        w_one_extra = srcA;
        w_one_c     = 1'b1;
        w_one_o     = 1'b0;
      end
      default: w_one_keep = 1'b1;
    endcase
    w_one_flags = w_one_keep ? r_flags
                             : pack_flags(w_one_res == '0, w_one_res[MSB], w_one_c, w_one_o);
  end

  always_comb begin
    w_sh_nxt = r_sh;
    w_c_nxt  = r_c;
    w_of_nxt = r_of;
    case (r_op)
      OP_RSL: begin w_c_nxt = r_sh[0];   w_sh_nxt = {1'b0, r_sh[MSB:1]};      end
      OP_LSL: begin w_c_nxt = r_sh[MSB]; w_sh_nxt = {r_sh[MSB-1:0], 1'b0};    end
      OP_RSA: begin w_c_nxt = r_sh[0];   w_sh_nxt = {r_sh[MSB], r_sh[MSB:1]}; end
      OP_LSA: begin
        w_c_nxt  = r_sh[MSB];
        w_sh_nxt = {r_sh[MSB-1:0], 1'b0};
        // MSB changes whenever the two top bits differ before the step
        w_of_nxt = r_of | (r_sh[MSB] ^ r_sh[MSB-1]);
      end
      OP_RSR: begin w_c_nxt = r_sh[0];   w_sh_nxt = {r_sh[0], r_sh[MSB:1]};     end
      OP_LSR: begin w_c_nxt = r_sh[MSB]; w_sh_nxt = {r_sh[MSB-1:0], r_sh[MSB]}; end
      // carry is the extra bit of a WIDTH+1 ring
      OP_RSC: begin w_c_nxt = r_sh[0];   w_sh_nxt = {r_c, r_sh[MSB:1]};         end
      OP_LSC: begin w_c_nxt = r_sh[MSB]; w_sh_nxt = {r_sh[MSB-1:0], r_c};       end
      default: ;
    endcase
  end

  seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (w_md_start),
    .is_div (opsel != OP_MUL),
    .a      (srcA),
    .b      (srcB),
    .busy   (w_md_busy),
    .done   (w_md_done),
    .hi     (w_md_hi),
    .lo     (w_md_lo)
  );

  always_comb begin
    w_md_res   = w_md_lo;
    w_md_extra = w_md_hi;
    w_md_flags = pack_flags(w_md_lo == '0, w_md_lo[MSB], 1'b0, 1'b0);
    if (r_op == OP_MUL) begin
      w_md_flags = pack_flags({w_md_hi, w_md_lo} == '0, w_md_hi[MSB],
                              w_md_hi != '0, w_md_hi != '0);
    end else if (r_op == OP_MOD) begin
      w_md_res   = w_md_hi;
      w_md_extra = '0;
      w_md_flags = pack_flags(w_md_hi == '0, w_md_hi[MSB], 1'b0, 1'b0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
      r_res   <= '0;
      r_extra <= '0;
      r_flags <= '0;
      r_op    <= '0;
      r_sh    <= '0;
      r_c     <= 1'b0;
      r_of    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ready <= 1'b0;
            r_op    <= opsel;
            if (w_to_shift) begin
              r_state <= S_SHIFT;
              r_cnt   <= {1'b0, w_n};
              r_sh    <= srcA;
              r_c     <= Cflag;
              r_of    <= (opsel == OP_LSA) ? 1'b0 : Oflag;
            end else if (w_to_md) begin
              r_state <= S_MULDIV;
            end else begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_res   <= w_one_res;
              r_extra <= w_one_extra;
              r_flags <= w_one_flags;
            end
          end
        end
        S_SHIFT: begin
          r_sh  <= w_sh_nxt;
          r_c   <= w_c_nxt;
          r_of  <= w_of_nxt;
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CNT_W'(1)) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_res   <= w_sh_nxt;
            r_extra <= '0;
            r_flags <= pack_flags(w_sh_nxt == '0, w_sh_nxt[MSB], w_c_nxt, w_of_nxt);
          end
        end
        S_MULDIV: begin
          if (w_md_done) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_res   <= w_md_res;
            r_extra <= w_md_extra;
            r_flags <= w_md_flags;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready     = r_ready;
  assign done      = r_done;
  assign res       = r_res;
  assign extra_res = r_extra;
  assign flags     = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_multicycle_alu                                            |
// | Description : Self-checking bench for multicycle_alu (WIDTH=16): directed  |
// |               cases, randomized ops against a behavioural model, reset     |
// |               abort and busy-start rejection.                              |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_multicycle_alu;
  import alu_pkg::*;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, Cflag, Oflag;
  logic [4:0]   opsel;
  logic [W-1:0] srcA, srcB;
  logic         ready, done;
  logic [W-1:0] res, extra_res;
  logic [3:0]   flags;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] prev_flags = 4'b0000;

  always #5 clk = ~clk;

  multicycle_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opsel(opsel),
    .srcA(srcA), .srcB(srcB), .Cflag(Cflag), .Oflag(Oflag),
    .ready(ready), .done(done), .res(res), .extra_res(extra_res), .flags(flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: results straight from arithmetic definitions.
  function automatic void model(input logic [4:0] op, input logic [W-1:0] a, b,
                                input logic c, o, input logic [3:0] pf,
                                output logic [W-1:0] r, x, output logic [3:0] f,
                                output int lat);
    int n, sum;
    logic cf, of, z, ng, keep;
    logic signed [W-1:0] sa;
    logic [W:0] ring, rr;
    logic [2*W-1:0] p;
    n = int'(b) % W;
    cf = c; of = o; r = '0; x = '0; lat = 1; keep = 1'b0;
    z = 1'b0; ng = 1'b0;
    case (op)
      OP_SHORT_B: r = b;
      OP_ADD: begin
        r = a + b; cf = (int'(a) + int'(b)) > 65535;
        sum = int'($signed(a)) + int'($signed(b)); of = (sum > 32767) || (sum < -32768);
      end
      OP_SUB: begin
        r = a - b; cf = a < b;
        sum = int'($signed(a)) - int'($signed(b)); of = (sum > 32767) || (sum < -32768);
      end
      OP_INC: begin r = a + 1; cf = (a == 16'hFFFF); of = (a == 16'h7FFF); end
      OP_DEC: begin r = a - 1; cf = (a == 16'h0000); of = (a == 16'h8000); end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_NEG: r = 16'h0000 - a;
      OP_MUL: begin
        p = {16'h0, a} * {16'h0, b}; r = p[W-1:0]; x = p[2*W-1:W];
        cf = (x != 0); of = cf; lat = W + 1;
      end
      OP_DIV, OP_MOD: begin
        if (b == 0) begin r = '1; x = a; cf = 1'b1; of = 1'b0; end
        else begin
          r = (op == OP_DIV) ? a / b : a % b;
          x = (op == OP_DIV) ? a % b : '0;
          cf = 1'b0; of = 1'b0; lat = W + 1;
        end
      end
      OP_RSL, OP_LSL, OP_RSA, OP_LSA, OP_RSR, OP_LSR, OP_RSC, OP_LSC: begin
        r = a;
        if (n != 0) begin
          lat = n + 1;
          ring = {c, a};
          case (op)
            OP_RSL: begin r = a >> n; cf = a[n-1]; end
            OP_LSL: begin r = a << n; cf = a[W-n]; end
            OP_RSA: begin sa = a; r = sa >>> n; cf = a[n-1]; end
            OP_LSA: begin
              r = a << n; cf = a[W-n]; of = 1'b0;
              for (int k = 1; k <= n; k++) if (a[W-1-k] != a[W-1]) of = 1'b1;
            end
            OP_RSR: begin r = (a >> n) | (a << (W - n)); cf = r[W-1]; end
            OP_LSR: begin r = (a << n) | (a >> (W - n)); cf = r[0]; end
            OP_RSC: begin rr = (ring >> n) | (ring << (W + 1 - n)); r = rr[W-1:0]; cf = rr[W]; end
            default: begin rr = (ring << n) | (ring >> (W + 1 - n)); r = rr[W-1:0]; cf = rr[W]; end
          endcase
        end
      end
      default: keep = 1'b1;
    endcase
    if (op == OP_MUL) begin z = ({x, r} == 0); ng = x[W-1]; end
    else begin z = (r == 0); ng = r[W-1]; end
    f = keep ? pf : {z, ng, cf, of};
  endfunction

  // Issue one op, wait for done (bounded), compare against the model.
  task automatic run(input logic [4:0] op, input logic [W-1:0] a, b,
                     input logic c, o, input bit poke);
    logic [W-1:0] er, ex;
    logic [3:0]   ef;
    int           lat, cyc, w;
    bit           got, rdy_bad;
    model(op, a, b, c, o, prev_flags, er, ex, ef, lat);
    w = 0;
    while (ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("ready_before_start", ready, 1'b1);
    opsel = op; srcA = a; srcB = b; Cflag = c; Oflag = o; start = 1'b1;
    @(posedge clk);
    cyc = 0; got = 0; rdy_bad = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      // a start while busy must be ignored
      if (poke && lat >= 4 && cyc == 2) begin
        start = 1'b1; opsel = OP_ADD; srcA = ~a; srcB = ~b; Cflag = ~c;
      end
      if (poke && lat >= 4 && cyc == 3) start = 1'b0;
      if (ready !== 1'b0) rdy_bad = 1;
      if (done === 1'b1) got = 1;
    end
    start = 1'b0;
    chk($sformatf("done_seen op%0d", op), got, 1'b1);
    chk($sformatf("latency op%0d", op), cyc, lat);
    chk($sformatf("ready_low op%0d", op), rdy_bad, 1'b0);
    chk($sformatf("res op%0d a=%h b=%h", op, a, b), res, er);
    chk($sformatf("extra op%0d a=%h b=%h", op, a, b), extra_res, ex);
    chk($sformatf("flags op%0d a=%h b=%h c=%b o=%b", op, a, b, c, o), flags, ef);
    prev_flags = ef;
    @(negedge clk);
    chk("done_one_cycle", done, 1'b0);
    chk("ready_after_done", ready, 1'b1);
  endtask

  initial begin
    logic [4:0]   rop;
    logic [W-1:0] ra, rb;
    bit           seen;

    rst = 1'b1; start = 1'b0; opsel = '0; srcA = '0; srcB = '0; Cflag = 1'b0; Oflag = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_res", res, 16'h0000);
    chk("rst_extra", extra_res, 16'h0000);
    chk("rst_flags", flags, 4'b0000);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    chk("add_res", res, 16'h0000);
    chk("add_flags", flags, 4'b1010);
    run(OP_RSA, 16'h8001, 16'd4, 1'b1, 1'b0, 1'b1);
    chk("rsa4_res", res, 16'hF800);
    chk("rsa4_cf", flags[FLAG_C], 1'b0);
    run(OP_RSA, 16'h8001, 16'd16, 1'b1, 1'b0, 1'b0);
    chk("rsa16_res", res, 16'h8001);
    chk("rsa16_cf", flags[FLAG_C], 1'b1);
    run(OP_LSC, 16'h8000, 16'd1, 1'b1, 1'b0, 1'b0);
    chk("lsc_res", res, 16'h0001);
    chk("lsc_cf", flags[FLAG_C], 1'b1);
    run(OP_MUL, 16'h1234, 16'h5678, 1'b0, 1'b0, 1'b1);
    chk("mul_prod", {extra_res, res}, 32'h0626_0060);
    chk("mul_cf_of", {flags[FLAG_C], flags[FLAG_O]}, 2'b11);

    // Reset in cycle 5 of a MUL: no done, outputs cleared, start ignored
    opsel = OP_MUL; srcA = 16'h00FF; srcB = 16'h0101; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1; start = 1'b1; opsel = OP_ADD;
    @(negedge clk);
    chk("abort_ready", ready, 1'b1);
    chk("abort_done", done, 1'b0);
    chk("abort_res", res, 16'h0000);
    chk("abort_extra", extra_res, 16'h0000);
    chk("abort_flags", flags, 4'b0000);
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1;
    end
    chk("abort_no_done", seen, 1'b0);
    prev_flags = 4'b0000;

    run(OP_DIV, 16'd1000, 16'd7, 1'b0, 1'b1, 1'b0);
    chk("div_q", res, 16'd142);
    chk("div_r", extra_res, 16'd6);
    run(OP_DIV, 16'd1000, 16'd0, 1'b0, 1'b0, 1'b0);
    chk("div0_res", res, 16'hFFFF);
    chk("div0_cf", flags[FLAG_C], 1'b1);
    run(OP_MOD, 16'd1000, 16'd7, 1'b1, 1'b1, 1'b0);
    run(5'd27, 16'h1234, 16'h4321, 1'b0, 1'b0, 1'b0);
    run(OP_LSA, 16'h4000, 16'd2, 1'b0, 1'b0, 1'b0);
    run(OP_SUB, 16'h8000, 16'h0001, 1'b0, 1'b0, 1'b0);

    // Randomized ops, back-to-back
    for (int i = 0; i < 80; i++) begin
      rop = 5'($urandom_range(0, 31));
      ra  = 16'($urandom);
      rb  = ($urandom_range(0, 4) == 0) ? 16'h0000 : 16'($urandom);
      run(rop, ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
